// File: rtl/logic_unit_pipe_pkg.sv
// Shared definitions for the bitwise logic unit: op field width and op codes.
// The ALU result mux imports the same op codes.
package logic_unit_defs;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_XOR   = 3'd2,
        OP_XNOR  = 3'd3,
        OP_NAND  = 3'd4,
        OP_NOR   = 3'd5,
        OP_NOTA  = 3'd6,
        OP_PASSB = 3'd7
    } op_e;

endpackage

// File: rtl/logic_unit_pipe_core.sv
// Purely combinational bitwise logic core; reused by the pipeline and the ALU.
module logic_unit_core
    import logic_unit_defs::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        case (op_e'(op))
            OP_AND:   result = a & b;
            OP_OR:    result = a | b;
            OP_XOR:   result = a ^ b;
            OP_XNOR:  result = ~(a ^ b);
            OP_NAND:  result = ~(a & b);
            OP_NOR:   result = ~(a | b);
            OP_NOTA:  result = ~a;
            OP_PASSB: result = b;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with result flags and an accumulator
// that can stand in for operand A.
module logic_unit_pipe
    import logic_unit_defs::*;
#(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    input  logic             acc_en,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             ones,
    output logic             parity,
    output logic [WIDTH-1:0] acc_q
);

    // Handshake: a beat moves on any edge where valid && ready. Once out_valid
    // rises, y and the flags hold until out_ready. Each stage advances when it
    // is empty or the stage after it is advancing, so in_ready follows
    // out_ready combinationally through both stages.
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [OP_W-1:0]  s1_op;
    logic             s1_acc_en;

    logic             s1_adv;
    logic             s2_adv;
    logic             s2_load;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] result;

    assign s2_adv    = !out_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign s2_load   = s2_adv && s1_valid;
    assign operand_a = s1_acc_en ? acc_q : s1_a;

    logic_unit_core #(.WIDTH(WIDTH)) u_core (
        .a      (operand_a),
        .b      (s1_b),
        .op     (s1_op),
        .result (result)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_op     <= '0;
            s1_acc_en <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a      <= a;
                s1_b      <= b;
                s1_op     <= op;
                s1_acc_en <= acc_en;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            y         <= '0;
            zero      <= 1'b0;
            ones      <= 1'b0;
            parity    <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                y      <= result;
                zero   <= (result == '0);
                ones   <= &result;
                parity <= ^result;
            end
        end
    end

    // Clear wins over write-back; the advancing beat already read the old value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= ACC_INIT;
        end else if (acc_clr) begin
            acc_q <= ACC_INIT;
        end else if (s2_load && s1_acc_en) begin
            acc_q <= result;
        end
    end

endmodule
